// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: index-mode encodings,
// saturating-counter step and table index hashing.
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Counters are at most 4 bits wide; callers truncate back to their width.
  function automatic logic [3:0] ctr_sat_next(input logic [3:0] ctr,
                                              input logic       taken,
                                              input int         width);
    logic [3:0] max_v;
    max_v = 4'((1 << width) - 1);
    if (taken) return (ctr == max_v) ? ctr : ctr + 4'd1;
    else       return (ctr == 4'd0)  ? ctr : ctr - 4'd1;
  endfunction

  function automatic logic [31:0] bp_index(input logic [63:0] pc,
                                           input logic [31:0] hist,
                                           input int          mode,
                                           input int          idx_bits);
    logic [31:0] mask;
    logic [31:0] idx;
    mask = 32'((64'd1 << idx_bits) - 64'd1);
    idx  = 32'((pc >> 2) & {32'd0, mask});
    if (mode == MODE_GSHARE) idx = idx ^ (hist & mask);
    return idx;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating up/down counter of the prediction table, cleared
// synchronously to a configurable initial value.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int               WIDTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             taken,
  output logic [WIDTH-1:0] ctr
);

  always_ff @(posedge clk) begin
    if (reset)   ctr <= INIT;
    else if (en) ctr <= WIDTH'(ctr_sat_next(4'(ctr), taken, WIDTH));
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: saturating-counter table (bimodal or gshare
// indexed) plus direct-mapped BTB, global history and resolve statistics.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 6,
  parameter int MODE      = MODE_BIMODAL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 predict_taken,
  output logic [XLEN-1:0]      predict_target,
  output logic                 predict_btb_hit,
  output logic [HIST_BITS-1:0] predict_hist,
  input  logic                 update_valid,
  input  logic [XLEN-1:0]      update_pc,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  input  logic [XLEN-1:0]      update_target,
  input  logic                 update_mispredict,
  output logic [HIST_BITS-1:0] ghr,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_THR  = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [ENTRIES-1:0][CTR_BITS-1:0] ctr_q;
  logic [ENTRIES-1:0]               ctr_en;
  logic [ENTRIES-1:0]               btb_vld_q;
  logic [ENTRIES-1:0][TAG-1:0]      btb_tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]     btb_tgt_q;
  logic [HIST_BITS-1:0]             ghr_q;
  logic [HIST_BITS-1:0]             ghr_nxt;
  logic [31:0]                      stat_branches_q;
  logic [31:0]                      stat_mispredicts_q;

  logic [31:0]         lk_idx, up_idx;
  logic [IDX-1:0]      lk_bidx, up_bidx;
  logic [CTR_BITS-1:0] lk_ctr;
  logic                lk_hit;

  assign lk_bidx = lookup_pc[IDX+1:2];
  assign up_bidx = update_pc[IDX+1:2];

  always_comb begin
    lk_idx = bp_index(64'(lookup_pc), 32'(ghr_q), MODE, IDX);
    up_idx = bp_index(64'(update_pc), 32'(update_hist), MODE, IDX);
  end

  // Counter table
  always_comb begin
    lk_ctr = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_en[i] = update_valid && (up_idx == 32'(i));
      if (lk_idx == 32'(i)) lk_ctr = ctr_q[i];
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_counter #(
      .WIDTH (CTR_BITS),
      .INIT  (CTR_INIT)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (ctr_en[i]),
      .taken (update_taken),
      .ctr   (ctr_q[i])
    );
  end

  // Lookup: reads pre-update state, so a same-cycle update is not bypassed
  assign lk_hit          = btb_vld_q[lk_bidx] && (btb_tag_q[lk_bidx] == lookup_pc[XLEN-1:IDX+2]);
  assign predict_btb_hit = lookup_valid && lk_hit;
  assign predict_taken   = predict_btb_hit && (lk_ctr >= CTR_THR);
  assign predict_target  = predict_btb_hit ? btb_tgt_q[lk_bidx] : '0;
  assign predict_hist    = ghr_q;
  assign ghr             = ghr_q;

  // BTB: only taken branches allocate, replacing any aliasing entry
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld_q <= '0;
      btb_tag_q <= '0;
      btb_tgt_q <= '0;
    end else if (update_valid && update_taken) begin
      btb_vld_q[up_bidx] <= 1'b1;
      btb_tag_q[up_bidx] <= update_pc[XLEN-1:IDX+2];
      btb_tgt_q[up_bidx] <= update_target;
    end
  end

  if (HIST_BITS == 1) begin : g_ghr1
    assign ghr_nxt = update_taken;
  end else begin : g_ghrn
    assign ghr_nxt = {ghr_q[HIST_BITS-2:0], update_taken};
  end

  always_ff @(posedge clk) begin
    if (reset)             ghr_q <= '0;
    else if (update_valid) ghr_q <= ghr_nxt;
  end

  // Statistics saturate rather than wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (update_valid) begin
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
      if (update_mispredict && stat_mispredicts_q != '1)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed table-driven bench for branch_predictor_bht in bimodal and gshare modes.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [5:0]  update_hist;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;

  logic        p0_taken, p0_hit, p1_taken, p1_hit;
  logic [31:0] p0_tgt, p1_tgt;
  logic [5:0]  p0_hist, p1_hist, p0_ghr, p1_ghr;
  logic [31:0] p0_br, p0_mp, p1_br, p1_mp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor_bht #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_taken(p0_taken), .predict_target(p0_tgt),
    .predict_btb_hit(p0_hit), .predict_hist(p0_hist),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .ghr(p0_ghr), .stat_branches(p0_br), .stat_mispredicts(p0_mp)
  );

  branch_predictor_bht #(.MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_taken(p1_taken), .predict_target(p1_tgt),
    .predict_btb_hit(p1_hit), .predict_hist(p1_hist),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .ghr(p1_ghr), .stat_branches(p1_br), .stat_mispredicts(p1_mp)
  );

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        et;
    logic        eh;
    logic [31:0] etgt;
    logic [5:0]  eghr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic [5:0] uh, input logic ut,
                       input logic [31:0] utgt, input logic um);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_hist = uh;
    update_taken = ut; update_target = utgt; update_mispredict = um;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          lv lpc     uv upc     ut utgt   um  et eh etgt   eghr
    vecs[0]  = '{1, 32'h10, 0, 32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  6'h00};
    vecs[1]  = '{1, 32'h10, 1, 32'h10, 1, 32'h40, 0, 0, 0, 32'h0,  6'h00};
    vecs[2]  = '{1, 32'h10, 1, 32'h10, 1, 32'h40, 0, 1, 1, 32'h40, 6'h01};
    vecs[3]  = '{1, 32'h10, 1, 32'h10, 1, 32'h40, 0, 1, 1, 32'h40, 6'h03};
    vecs[4]  = '{1, 32'h10, 1, 32'h10, 0, 32'h0,  1, 1, 1, 32'h40, 6'h07};
    vecs[5]  = '{1, 32'h10, 1, 32'h10, 0, 32'h0,  0, 1, 1, 32'h40, 6'h0E};
    vecs[6]  = '{1, 32'h10, 1, 32'h10, 0, 32'h0,  1, 0, 1, 32'h40, 6'h1C};
    vecs[7]  = '{1, 32'h10, 1, 32'h10, 0, 32'h0,  0, 0, 1, 32'h40, 6'h38};
    vecs[8]  = '{1, 32'h10, 1, 32'h10, 1, 32'h40, 0, 0, 1, 32'h40, 6'h30};
    vecs[9]  = '{1, 32'h10, 0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h40, 6'h21};
    vecs[10] = '{0, 32'h10, 1, 32'h10, 1, 32'h40, 0, 0, 0, 32'h0,  6'h21};
    vecs[11] = '{1, 32'h10, 1, 32'h110,1, 32'h80, 1, 1, 1, 32'h40, 6'h03};
    vecs[12] = '{1, 32'h10, 0, 32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  6'h07};
    vecs[13] = '{1, 32'h110,0, 32'h0,  0, 32'h0,  0, 1, 1, 32'h80, 6'h07};
    vecs[14] = '{1, 32'h10, 1, 32'h10, 0, 32'h0,  0, 0, 0, 32'h0,  6'h07};
    vecs[15] = '{1, 32'h110,0, 32'h0,  0, 32'h0,  0, 1, 1, 32'h80, 6'h0E};

    step();
    reset = 1'b0;

    #2;
    chk("reset_br", p0_br, 0);
    chk("reset_mp", p0_mp, 0);

    // Bimodal training, saturation, hazard, aliasing, lookup_valid gating
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, 6'h0,
            vecs[i].ut, vecs[i].utgt, vecs[i].um);
      #2;
      chk($sformatf("v%0d_taken", i), 32'(p0_taken), 32'(vecs[i].et));
      chk($sformatf("v%0d_hit",   i), 32'(p0_hit),   32'(vecs[i].eh));
      chk($sformatf("v%0d_tgt",   i), p0_tgt,        vecs[i].etgt);
      chk($sformatf("v%0d_ghr",   i), 32'(p0_ghr),   32'(vecs[i].eghr));
      chk($sformatf("v%0d_phist", i), 32'(p0_hist),  32'(vecs[i].eghr));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("stat_branches", p0_br, 11);
    chk("stat_mispredicts", p0_mp, 3);

    // Reset dominates a simultaneous update
    reset = 1'b1;
    drive(1, 32'h10, 1, 32'h10, 0, 1, 32'h40, 1);
    step();
    reset = 1'b0;
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_upd_br", p0_br, 0);
    chk("rst_upd_mp", p0_mp, 0);
    chk("rst_upd_hit", 32'(p0_hit), 0);
    chk("rst_upd_ghr", 32'(p0_ghr), 0);
    // Counter must still be 1: NT->0, T->1 leaves it not-taken
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 32'h10, 0, 1, 32'h40, 0);
    step();
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_ctr_taken", 32'(p0_taken), 0);
    chk("rst_ctr_hit", 32'(p0_hit), 1);
    chk("rst_ghr", 32'(p0_ghr), 6'h01);

    // Statistics saturation
    drive(0, 0, 1, 32'h20, 0, 0, 0, 0);
    force dut0.stat_branches_q = 32'hFFFF_FFFF;
    #1;
    release dut0.stat_branches_q;
    step();
    drive(0, 0, 1, 32'h20, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("stat_sat", p0_br, 32'hFFFF_FFFF);

    // Gshare: train entry 0^5 via update_hist, then outcomes 1,0,1 -> ghr=5
    do_reset();
    drive(0, 0, 1, 32'h0, 6'h05, 1, 32'h100, 0);
    step();
    drive(0, 0, 1, 32'h40, 6'h00, 0, 0, 0);
    step();
    drive(0, 0, 1, 32'h40, 6'h00, 1, 32'h44, 1);
    step();
    drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("gs_ghr", 32'(p1_ghr), 6'h05);
    chk("gs_phist", 32'(p1_hist), 6'h05);
    chk("gs_taken", 32'(p1_taken), 1);
    chk("gs_hit", 32'(p1_hit), 1);
    chk("gs_tgt", p1_tgt, 32'h100);
    chk("gs_br", p1_br, 3);
    chk("gs_mp", p1_mp, 1);
    // In bimodal mode the same stimulus leaves pc 0x0 at counter 2 too, but pc 0x40 at 1
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    #2;
    chk("bm_pc40_taken", 32'(p0_taken), 0);
    chk("bm_pc40_tgt", p0_tgt, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
